// File: rtl/exception_ctrl.sv
// Precise-exception controller: priority pick, EPC/CAUSE capture,
// timed pipeline flush, handler redirect and eret return.
module exception_ctrl #(
   parameter int          XLEN      = 32,
   parameter int          N_SRC     = 4,
   parameter int          CAUSE_W   = 3,
   parameter int unsigned VECTOR    = 60,
   parameter int          FLUSH_CYC = 3,
   parameter int          CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_SRC-1:0]        exc_req,
   input  logic [N_SRC*XLEN-1:0]   exc_pc,
   input  logic                    eret,
   output logic                    flush,
   output logic                    pc_redir_vld,
   output logic [XLEN-1:0]         pc_redir,
   output logic [XLEN-1:0]         epc,
   output logic [CAUSE_W-1:0]      cause,
   output logic                    in_handler,
   output logic                    double_fault,
   output logic [CNT_W-1:0]        exc_count
);

   localparam int FC_W = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC);
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);
   localparam logic [XLEN-1:0] VEC = XLEN'(VECTOR);

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      REDIR,
      HANDLER,
      RETURN
   } state_t;

   state_t            state;
   logic [FC_W-1:0]   fcnt;
   logic              any_req;
   logic [XLEN-1:0]   win_pc;
   logic [CAUSE_W-1:0] win_cause;

   assign any_req = |exc_req;

   // Scan from the top so the lowest set index wins.
   always_comb begin
      win_pc    = '0;
      win_cause = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (exc_req[i]) begin
            win_pc    = exc_pc[i*XLEN +: XLEN];
            win_cause = CAUSE_W'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         fcnt         <= '0;
         flush        <= 1'b0;
         pc_redir_vld <= 1'b0;
         pc_redir     <= '0;
         epc          <= '0;
         cause        <= '0;
         in_handler   <= 1'b0;
         double_fault <= 1'b0;
         exc_count    <= '0;
      end else begin
         if (state != IDLE && any_req)
            double_fault <= 1'b1;

         unique case (state)
            IDLE: begin
               flush        <= 1'b0;
               pc_redir_vld <= 1'b0;
               pc_redir     <= '0;
               in_handler   <= 1'b0;
               if (any_req) begin
                  epc   <= win_pc;
                  cause <= win_cause;
                  if (exc_count != '1)
                     exc_count <= exc_count + 1'b1;
                  fcnt  <= FC_LOAD;
                  flush <= 1'b1;
                  state <= FLUSH;
               end
            end

            FLUSH: begin
               flush <= 1'b1;
               if (fcnt == '0) begin
                  pc_redir_vld <= 1'b1;
                  pc_redir     <= VEC;
                  state        <= REDIR;
               end else begin
                  fcnt <= fcnt - 1'b1;
               end
            end

            REDIR: begin
               flush        <= 1'b0;
               pc_redir_vld <= 1'b0;
               pc_redir     <= '0;
               in_handler   <= 1'b1;
               state        <= HANDLER;
            end

            HANDLER: begin
               in_handler <= 1'b1;
               if (eret) begin
                  flush        <= 1'b1;
                  pc_redir_vld <= 1'b1;
                  pc_redir     <= epc;
                  state        <= RETURN;
               end
            end

            RETURN: begin
               flush        <= 1'b0;
               pc_redir_vld <= 1'b0;
               pc_redir     <= '0;
               in_handler   <= 1'b0;
               state        <= IDLE;
            end

            default: begin
               flush        <= 1'b0;
               pc_redir_vld <= 1'b0;
               pc_redir     <= '0;
               in_handler   <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule
